// File: rtl/i2c_ges_pkg.sv
// Shared types and constants for the gesture-sensor I2C target emulator.
package i2c_ges_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_REG,
      ST_REG_ACK,
      ST_WDATA,
      ST_WACK,
      ST_RDATA,
      ST_RACK
   } i2c_state_t;

   localparam logic [7:0] REG_ID_L = 8'h00;
   localparam logic [7:0] REG_ID_H = 8'h01;
   localparam logic [7:0] REG_GES  = 8'h43;
   localparam logic [7:0] REG_BANK = 8'hEF;

   localparam logic [7:0] GES_UP    = 8'h01;
   localparam logic [7:0] GES_DOWN  = 8'h02;
   localparam logic [7:0] GES_LEFT  = 8'h04;
   localparam logic [7:0] GES_RIGHT = 8'h08;

   // Bank 1 hides everything except the bank select itself.
   function automatic logic [7:0] rd_mux(input logic [7:0] ptr, input logic bank,
                                         input logic [15:0] id, input logic [7:0] ges);
      logic [7:0] d;
      d = 8'h00;
      if (ptr == REG_BANK) begin
         d = {7'b0, bank};
      end else if (!bank) begin
         case (ptr)
            REG_ID_L: d = id[7:0];
            REG_ID_H: d = id[15:8];
            REG_GES:  d = ges;
            default:  d = 8'h00;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/i2c_ges_target_filter.sv
// Two-flop synchronizer plus stability filter for one I2C line.
module i2c_in_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [2:0] CNT_LOAD = 3'(FILT_LEN - 1);

   logic [1:0] sync_q;
   logic [2:0] cnt;

   // Down-counter reloads whenever the synchronized value matches the accepted level.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync_q <= 2'b11;
         level  <= 1'b1;
         rise   <= 1'b0;
         fall   <= 1'b0;
         cnt    <= CNT_LOAD;
      end else begin
         sync_q <= {sync_q[0], raw};
         rise   <= 1'b0;
         fall   <= 1'b0;
         if (sync_q[1] == level) begin
            cnt <= CNT_LOAD;
         end else if (cnt == 3'd0) begin
            level <= sync_q[1];
            rise  <= sync_q[1];
            fall  <= ~sync_q[1];
            cnt   <= CNT_LOAD;
         end else begin
            cnt <= cnt - 3'd1;
         end
      end
   end

endmodule

// File: rtl/i2c_ges_target.sv
// I2C target emulating the gesture sensor register interface for loopback tests.
//
// state       | meaning
// ST_IDLE     | waiting for START
// ST_ADDR     | shifting in device address + R/W
// ST_ADDR_ACK | driving address ACK
// ST_REG      | shifting in register pointer
// ST_REG_ACK  | driving register ACK
// ST_WDATA    | shifting in write data
// ST_WACK     | driving write data ACK
// ST_RDATA    | shifting out read data
// ST_RACK     | sampling master ACK/NACK
module i2c_ges_target
   import i2c_ges_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR = 7'h73,
   parameter logic [15:0] PART_ID  = 16'h7620,
   parameter int          FILT_LEN = 3
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   input  logic [7:0] ges_set,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] ges_flag,
   output logic       busy
);

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;

   i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .raw     (scl_i),
      .level   (scl),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .raw     (sda_i),
      .level   (sda),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   i2c_state_t state;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic [7:0] reg_ptr;
   logic       rw;
   logic       bank;
   logic       ack_phase;
   logic       mack_n;

   logic       start_det, stop_det;
   logic [7:0] rx_byte;
   logic [7:0] tx_byte;
   logic       tx_is_ges;

   assign start_det = sda_fall & scl;
   assign stop_det  = sda_rise & scl;
   assign rx_byte   = {shift[6:0], sda};
   assign tx_byte   = rd_mux(reg_ptr, bank, PART_ID, ges_flag);
   assign tx_is_ges = ~bank & (reg_ptr == REG_GES);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= 3'd0;
         shift     <= 8'h00;
         reg_ptr   <= 8'h00;
         rw        <= 1'b0;
         bank      <= 1'b0;
         ack_phase <= 1'b0;
         mack_n    <= 1'b0;
         sda_oe    <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= 8'h00;
         wr_data   <= 8'h00;
         ges_flag  <= 8'h00;
         busy      <= 1'b0;
      end else begin
         wr_valid <= 1'b0;
         ges_flag <= ges_flag | ges_set;

         if (stop_det) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            sda_oe <= 1'b0;
         end else if (start_det) begin
            state     <= ST_ADDR;
            busy      <= 1'b1;
            sda_oe    <= 1'b0;
            bit_cnt   <= 3'd0;
            ack_phase <= 1'b0;
         end else begin
            case (state)
               ST_ADDR, ST_REG, ST_WDATA: begin
                  if (scl_rise) begin
                     shift   <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        ack_phase <= 1'b0;
                        if (state == ST_ADDR) begin
                           if (rx_byte[7:1] == DEV_ADDR) begin
                              rw    <= rx_byte[0];
                              state <= ST_ADDR_ACK;
                           end else begin
                              state <= ST_IDLE;
                           end
                        end else if (state == ST_REG) begin
                           reg_ptr <= rx_byte;
                           state   <= ST_REG_ACK;
                        end else begin
                           wr_valid <= 1'b1;
                           wr_addr  <= reg_ptr;
                           wr_data  <= rx_byte;
                           if (reg_ptr == REG_BANK) bank <= rx_byte[0];
                           reg_ptr  <= reg_ptr + 8'd1;
                           state    <= ST_WACK;
                        end
                     end
                  end
               end

               // First falling edge starts the ACK, the one after the 9th rise ends it.
               ST_ADDR_ACK, ST_REG_ACK, ST_WACK: begin
                  if (scl_rise) begin
                     ack_phase <= 1'b1;
                  end else if (scl_fall) begin
                     if (!ack_phase) begin
                        sda_oe <= 1'b1;
                     end else begin
                        ack_phase <= 1'b0;
                        bit_cnt   <= 3'd0;
                        if (state == ST_ADDR_ACK && rw) begin
                           shift  <= tx_byte;
                           sda_oe <= ~tx_byte[7];
                           state  <= ST_RDATA;
                           if (tx_is_ges) ges_flag <= ges_set;
                        end else begin
                           sda_oe <= 1'b0;
                           state  <= (state == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
                        end
                     end
                  end
               end

               ST_RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state     <= ST_RACK;
                        ack_phase <= 1'b0;
                     end
                  end else if (scl_fall) begin
                     shift  <= {shift[6:0], 1'b0};
                     sda_oe <= ~shift[6];
                  end
               end

               // After a NACK the state parks here until STOP or repeated START.
               ST_RACK: begin
                  if (scl_rise && !ack_phase) begin
                     ack_phase <= 1'b1;
                     mack_n    <= sda;
                     if (!sda) reg_ptr <= reg_ptr + 8'd1;
                  end else if (scl_fall) begin
                     if (!ack_phase) begin
                        sda_oe <= 1'b0;
                     end else if (!mack_n) begin
                        shift     <= tx_byte;
                        sda_oe    <= ~tx_byte[7];
                        bit_cnt   <= 3'd0;
                        ack_phase <= 1'b0;
                        state     <= ST_RDATA;
                        if (tx_is_ges) ges_flag <= ges_set;
                     end
                  end
               end

               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_ges_target.sv
// Directed bench: bit-banged I2C master against the gesture target emulator.
module tb_i2c_ges_target;

   localparam int Q   = 8;  // sys_clk cycles per quarter SCL period
   localparam int LAT = 6;  // posedges from an SCL pin change to the FSM reacting (FILT_LEN=3)

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       scl_m   = 1'b1;
   logic       sda_m   = 1'b1;
   logic       glitch  = 1'b0;
   logic [7:0] ges_set = 8'h00;
   logic       sda_oe, wr_valid, busy;
   logic [7:0] wr_addr, wr_data, ges_flag;
   logic       sda_line;

   assign sda_line = (sda_m & ~sda_oe) ^ glitch;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int oe_cnt = 0;
   logic [7:0] wr_a_log [64];
   logic [7:0] wr_d_log [64];

   i2c_ges_target dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .scl_i    (scl_m),
      .sda_i    (sda_line),
      .sda_oe   (sda_oe),
      .ges_set  (ges_set),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .ges_flag (ges_flag),
      .busy     (busy)
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (wr_valid && wr_cnt < 64) begin
         wr_a_log[wr_cnt] = wr_addr;
         wr_d_log[wr_cnt] = wr_data;
         wr_cnt++;
      end
      if (sda_oe) oe_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   // gs: gesture pulse timed to hit the FSM on this bit's falling edge; gl: 1-cycle SDA glitch while SCL high
   task automatic i2c_bit(input logic b, input logic [7:0] gs, input logic gl, output logic s);
      sda_m = b; tick(Q);
      scl_m = 1'b1;
      if (gl) begin
         tick(Q / 2); glitch = 1'b1; tick(1); glitch = 1'b0; tick(Q - Q / 2 - 1);
      end else begin
         tick(Q);
      end
      s = sda_line;
      scl_m = 1'b0;
      if (gs != 8'h00) begin
         tick(LAT - 1); ges_set = gs; tick(1); ges_set = 8'h00; tick(Q - LAT);
      end else begin
         tick(Q);
      end
   endtask

   task automatic wr_byte(input logic [7:0] b, input logic [7:0] gs_ack, input int gl_bit,
                          output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) i2c_bit(b[i], 8'h00, (i == gl_bit), s);
      i2c_bit(1'b1, gs_ack, 1'b0, ack);
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         i2c_bit(1'b1, 8'h00, 1'b0, s);
         d[i] = s;
      end
      i2c_bit(mack, 8'h00, 1'b0, s);
   endtask

   task automatic write_reg(input logic [7:0] r, input logic [7:0] v, output logic [2:0] acks);
      i2c_start();
      wr_byte(8'hE6, 8'h00, -1, acks[2]);
      wr_byte(r, 8'h00, -1, acks[1]);
      wr_byte(v, 8'h00, -1, acks[0]);
      i2c_stop();
   endtask

   task automatic read_reg(input logic [7:0] r, input logic [7:0] gs, output logic [7:0] d,
                           output logic [2:0] acks);
      i2c_start();
      wr_byte(8'hE6, 8'h00, -1, acks[2]);
      wr_byte(r, 8'h00, -1, acks[1]);
      i2c_start();
      wr_byte(8'hE7, gs, -1, acks[0]);
      rd_byte(1'b1, d);
      i2c_stop();
   endtask

   task automatic test_reset();
      ges_set = 8'h80;
      tick(4);
      checks++; if (ges_flag !== 8'h00) begin errors++; $display("FAIL rst_ges_flag: got %h expected 00", ges_flag); end
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe: got %b expected 0", sda_oe); end
      checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL rst_wr_valid: got %b expected 0", wr_valid); end
      checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL rst_wr_addr: got %h expected 00", wr_addr); end
      checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data: got %h expected 00", wr_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      ges_set = 8'h00;
      tick(2);
      sys_rst = 1'b0;
      tick(10);
   endtask

   task automatic test_reset_mid();
      logic s;
      i2c_start();
      for (int i = 7; i >= 0; i--) i2c_bit(((8'hE6 >> i) & 8'h01) != 0, 8'h00, 1'b0, s);
      sda_m = 1'b1; tick(Q);
      checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL midrst_ack_drive: got %b expected 1", sda_oe); end
      sys_rst = 1'b1;
      #1;
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midrst_release: got %b expected 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      tick(2);
      sys_rst = 1'b0;
      scl_m = 1'b1;
      tick(3 * Q);
   endtask

   task automatic test_bank();
      logic [2:0] acks;
      logic [7:0] d;
      int base;
      base = wr_cnt;
      i2c_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bank_busy_start: got %b expected 1", busy); end
      wr_byte(8'hE6, 8'h00, -1, acks[2]);
      wr_byte(8'hEF, 8'h00, -1, acks[1]);
      wr_byte(8'h00, 8'h00, -1, acks[0]);
      i2c_stop();
      tick(Q);
      checks++; if (acks !== 3'b000) begin errors++; $display("FAIL bank_acks: got %b expected 000", acks); end
      checks++; if (wr_cnt - base !== 1) begin errors++; $display("FAIL bank_wr_count: got %0d expected 1", wr_cnt - base); end
      checks++; if (wr_a_log[base] !== 8'hEF) begin errors++; $display("FAIL bank_wr_addr: got %h expected EF", wr_a_log[base]); end
      checks++; if (wr_d_log[base] !== 8'h00) begin errors++; $display("FAIL bank_wr_data: got %h expected 00", wr_d_log[base]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bank_busy_stop: got %b expected 0", busy); end
      read_reg(8'hEF, 8'h00, d, acks);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL bank0_readback: got %h expected 00", d); end
      write_reg(8'hEF, 8'h01, acks);
      read_reg(8'h00, 8'h00, d, acks);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL bank1_id_hidden: got %h expected 00", d); end
      read_reg(8'hEF, 8'h00, d, acks);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL bank1_readback: got %h expected 01", d); end
      write_reg(8'hEF, 8'h00, acks);
      checks++; if (acks !== 3'b000) begin errors++; $display("FAIL bank_restore_acks: got %b expected 000", acks); end
   endtask

   task automatic test_part_id();
      logic [2:0] acks;
      logic [7:0] d0, d1;
      int oe0;
      i2c_start();
      wr_byte(8'hE6, 8'h00, -1, acks[2]);
      wr_byte(8'h00, 8'h00, -1, acks[1]);
      i2c_start();
      wr_byte(8'hE7, 8'h00, -1, acks[0]);
      rd_byte(1'b0, d0);
      rd_byte(1'b1, d1);
      oe0 = oe_cnt;
      tick(2 * Q);
      checks++; if (acks !== 3'b000) begin errors++; $display("FAIL id_acks: got %b expected 000", acks); end
      checks++; if (d0 !== 8'h20) begin errors++; $display("FAIL id_low: got %h expected 20", d0); end
      checks++; if (d1 !== 8'h76) begin errors++; $display("FAIL id_high: got %h expected 76", d1); end
      checks++; if (sda_oe !== 1'b0 || oe_cnt != oe0) begin errors++; $display("FAIL id_release_after_nack: got oe=%b cycles=%0d expected 0", sda_oe, oe_cnt - oe0); end
      i2c_stop();
   endtask

   task automatic test_ges_clear();
      logic [2:0] acks;
      logic [7:0] d;
      ges_set = 8'h04; tick(1); ges_set = 8'h00; tick(2);
      checks++; if (ges_flag !== 8'h04) begin errors++; $display("FAIL ges_set_flag: got %h expected 04", ges_flag); end
      read_reg(8'h43, 8'h00, d, acks);
      checks++; if (d !== 8'h04) begin errors++; $display("FAIL ges_read1: got %h expected 04", d); end
      checks++; if (ges_flag !== 8'h00) begin errors++; $display("FAIL ges_cleared: got %h expected 00", ges_flag); end
      read_reg(8'h43, 8'h00, d, acks);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL ges_read2: got %h expected 00", d); end
   endtask

   task automatic test_set_wins();
      logic [2:0] acks;
      logic [7:0] d;
      ges_set = 8'h02; tick(1); ges_set = 8'h00; tick(2);
      read_reg(8'h43, 8'h01, d, acks);
      checks++; if (d !== 8'h02) begin errors++; $display("FAIL setwins_byte: got %h expected 02", d); end
      checks++; if (ges_flag !== 8'h01) begin errors++; $display("FAIL setwins_flag: got %h expected 01", ges_flag); end
      read_reg(8'h43, 8'h00, d, acks);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL setwins_reread: got %h expected 01", d); end
   endtask

   task automatic test_wrong_addr();
      logic a0, a1, a2;
      logic [2:0] acks;
      logic [7:0] d;
      int oe0, base;
      oe0 = oe_cnt;
      base = wr_cnt;
      i2c_start();
      wr_byte(8'h52, 8'h00, -1, a0);
      wr_byte(8'h10, 8'h00, -1, a1);
      wr_byte(8'hAA, 8'h00, -1, a2);
      i2c_stop();
      tick(Q);
      checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL wrong_addr_nacks: got %b expected 111", {a0, a1, a2}); end
      checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL wrong_addr_oe: got %0d driven cycles expected 0", oe_cnt - oe0); end
      checks++; if (wr_cnt != base) begin errors++; $display("FAIL wrong_addr_wr: got %0d writes expected 0", wr_cnt - base); end
      read_reg(8'h00, 8'h00, d, acks);
      checks++; if (d !== 8'h20 || acks !== 3'b000) begin errors++; $display("FAIL wrong_addr_recover: got %h/%b expected 20/000", d, acks); end
   endtask

   task automatic test_burst();
      logic [4:0] acks;
      logic s;
      int base;
      base = wr_cnt;
      i2c_start();
      wr_byte(8'hE6, 8'h00, -1, acks[4]);
      wr_byte(8'hFE, 8'h00, -1, acks[3]);
      wr_byte(8'hA1, 8'h00, -1, acks[2]);
      wr_byte(8'hB2, 8'h00, 7, acks[1]);
      wr_byte(8'hC3, 8'h00, -1, acks[0]);
      i2c_bit(1'b1, 8'h00, 1'b0, s);
      i2c_bit(1'b1, 8'h00, 1'b0, s);
      i2c_bit(1'b0, 8'h00, 1'b0, s);
      i2c_bit(1'b1, 8'h00, 1'b0, s);
      i2c_stop();
      tick(2 * Q);
      checks++; if (acks !== 5'b00000) begin errors++; $display("FAIL burst_acks: got %b expected 00000", acks); end
      checks++; if (wr_cnt - base !== 3) begin errors++; $display("FAIL burst_wr_count: got %0d expected 3", wr_cnt - base); end
      checks++; if (wr_a_log[base] !== 8'hFE || wr_d_log[base] !== 8'hA1) begin errors++; $display("FAIL burst_w0: got %h/%h expected FE/A1", wr_a_log[base], wr_d_log[base]); end
      checks++; if (wr_a_log[base+1] !== 8'hFF || wr_d_log[base+1] !== 8'hB2) begin errors++; $display("FAIL burst_w1: got %h/%h expected FF/B2", wr_a_log[base+1], wr_d_log[base+1]); end
      checks++; if (wr_a_log[base+2] !== 8'h00 || wr_d_log[base+2] !== 8'hC3) begin errors++; $display("FAIL burst_w2: got %h/%h expected 00/C3", wr_a_log[base+2], wr_d_log[base+2]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy: got %b expected 0", busy); end
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_bank();
      test_part_id();
      test_ges_clear();
      test_set_wins();
      test_wrong_addr();
      test_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_ges_target.md
Name: i2c_ges_target

Overview:
- Synthesizable I2C target (slave) that emulates the gesture sensor's register interface at the far end of the team's I2C master.
- Used as an on-FPGA loopback partner: the master's configuration writes and gesture-flag reads can be exercised without the real sensor.
- Samples SCL/SDA with sys_clk, decodes the protocol and drives SDA open-drain.
- Exposes master writes and accepts injected gesture events from test logic.

Parameters:
- DEV_ADDR, 7'h73: 7-bit device address the block answers to.
- PART_ID, 16'h7620: part ID; reg 0x00 returns [7:0], reg 0x01 returns [15:8].
- FILT_LEN, 3: consecutive identical sys_clk samples needed to accept a new SCL/SDA level (range 1..7).

Ports:
- sys_clk, in, 1: system clock, at least 20x the SCL rate.
- sys_rst, in, 1: asynchronous reset, active-high.
- scl_i, in, 1: SCL line, asynchronous.
- sda_i, in, 1: SDA line, asynchronous.
- sda_oe, out, 1: 1 = pull SDA low, 0 = release SDA.
- ges_set, in, 8: per-bit set pulses ORed into the gesture flag register (0x01 up, 0x02 down, 0x04 left, 0x08 right, ...).
- wr_valid, out, 1: one-cycle pulse per write data byte the block ACKs.
- wr_addr, out, 8: register address for the wr_valid pulse.
- wr_data, out, 8: data byte for the wr_valid pulse.
- ges_flag, out, 8: current gesture flag register.
- busy, out, 1: high from START to STOP.

Behaviour:
- Reset values: sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, ges_flag=0, busy=0, bank=0, reg pointer=0. Filtered SCL/SDA reset to 1.
- Input conditioning: 2-FF synchronizer on each line, then a FILT_LEN stability filter. All edge and condition detection uses the filtered levels.
- Protocol conditions:
  - START: SDA falls while SCL=1. Repeated START is accepted in any state and returns to ADDR.
  - STOP: SDA rises while SCL=1. Goes to IDLE from any state.
- Bit timing: data is sampled on the SCL rising edge; sda_oe changes only on the SCL falling edge.
- Bit counter: 3 bits, MSB first. A byte is complete after the 8th rising edge.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WACK, RDATA, RACK.
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If addr[7:1]==DEV_ADDR, go to ADDR_ACK; otherwise go to IDLE and never drive SDA.
  - ADDR_ACK: drive 0 for one SCL period. Then go to RDATA if R/W=1, else REG.
  - REG: shift the byte into the reg pointer, then REG_ACK (always ACK), then WDATA.
  - WDATA: on byte complete, pulse wr_valid (wr_addr = reg pointer, wr_data = byte) and ACK in WACK.
    - A write to 0xEF updates bank from bit0.
    - The reg pointer increments, wrapping 0xFF->0x00.
    - Then return to WDATA.
  - RDATA: drive reg[pointer] MSB first. sda_oe = ~bit, so 1-bits release the line.
  - RACK: release SDA and sample the master's ACK on the rising edge.
    - ACK (0): pointer++, back to RDATA.
    - NACK (1): wait in RACK for STOP or repeated START.
- Read map (bank 0):
  - 0x00 = PART_ID[7:0]
  - 0x01 = PART_ID[15:8]
  - 0x43 = ges_flag
  - 0xEF = {7'b0, bank}
  - all other addresses read 0x00
- Read map (bank 1): all addresses read 0x00 except 0xEF.
- Read data is latched into the shift register at the SCL falling edge that begins the byte.
- ges_flag clear-on-read: cleared in the cycle the 0x43 byte (bank 0) is latched for transmit.
  - A ges_set bit asserted in that same cycle survives (set wins).
  - ges_set is applied every cycle, including during reset release, but not while sys_rst=1.
- Reset mid-transfer: asynchronous return to IDLE and SDA released immediately.
- Simultaneous START and STOP detection is impossible (SDA has only one edge per cycle). A STOP in the middle of a byte discards the partial byte with no wr_valid.
- busy: set on START, cleared on STOP.

Decomposition:
- Package i2c_ges_pkg holds:
  - the state enum
  - register address constants (REG_ID_L=0x00, REG_ID_H=0x01, REG_GES=0x43, REG_BANK=0xEF)
  - gesture bit constants
- Sub-module i2c_in_filter: synchronizer plus stability filter, instantiated once per line. Outputs the filtered level plus rise/fall strobes.

Test Plan:
- Write 0x73<<1|0, reg 0xEF, data 0x00 -> three ACKs; wr_valid once with wr_addr=0xEF, wr_data=0x00; bank=0.
- Set reg 0x00, repeated START, read 2 bytes (ACK then NACK) -> data 0x20, 0x76; SDA released after the NACK.
- Pulse ges_set=0x04, then read reg 0x43 -> byte 0x04, ges_flag=0 afterwards. A second read returns 0x00.
- Pulse ges_set=0x01 in the exact cycle 0x43 is latched -> byte carries the old value and ges_flag=0x01 afterwards.
- Address 0x29 write -> sda_oe stays 0 for the whole transaction, no wr_valid, FSM returns to IDLE.
- Burst-write 3 bytes starting at reg 0xFE -> wr_addr sequence 0xFE, 0xFF, 0x00. A STOP after 4 bits of a fourth byte -> no fourth wr_valid. A 1-cycle SDA glitch is ignored.
